// File: rtl/grid_pixel_streamer.sv
// Renders a software-programmed cell bitmap as a raster of 24-bit pixels on AXI-Stream.
// Bitmap, colours and run control live in an AXI-Lite register file on the same clock.
module grid_pixel_streamer #(
  parameter int X_SIZE              = 640,
  parameter int Y_SIZE              = 480,
  parameter int CELL_W              = 20,
  parameter int CELL_H              = 20,
  parameter int GRID_COLS           = 32,
  parameter int GRID_ROWS           = 24,
  parameter int AXI_LITE_ADDR_WIDTH = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  output logic [23:0]                    out_stream_tdata,
  output logic                           out_stream_tvalid,
  input  logic                           out_stream_tready,
  output logic                           out_stream_tuser,
  output logic                           out_stream_tlast
);

  localparam int IW = AXI_LITE_ADDR_WIDTH - 2;
  localparam logic [IW-1:0] A_FG   = IW'(32);
  localparam logic [IW-1:0] A_BG   = IW'(33);
  localparam logic [IW-1:0] A_CTRL = IW'(34);
  localparam logic [IW-1:0] A_STAT = IW'(35);
  localparam logic [IW-1:0] A_ROWS = IW'(GRID_ROWS);
  localparam logic [15:0] X_LAST  = 16'(X_SIZE - 1);
  localparam logic [15:0] Y_LAST  = 16'(Y_SIZE - 1);
  localparam logic [15:0] CW_LAST = 16'(CELL_W - 1);
  localparam logic [15:0] CH_LAST = 16'(CELL_H - 1);
  localparam logic [15:0] N_COLS  = 16'(GRID_COLS);
  localparam logic [15:0] N_ROWS  = 16'(GRID_ROWS);

  typedef enum logic [2:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_COMMIT, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_VALID} rst_t;

  wst_t           wst_q, wst_d;
  rst_t           rst_q, rst_d;
  logic [IW-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
  logic [31:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic [1:0]     bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]    bmp_q [32];
  logic [31:0]    bmp_d [32];
  logic [23:0]    fg_q, fg_d, bg_q, bg_d, fg_sh_q, fg_sh_d, bg_sh_q, bg_sh_d;
  logic           en_q, en_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic [15:0]    x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d, col_q, col_d, row_q, row_d;
  logic [23:0]    tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d, flast_q, flast_d;
  logic [31:0]    old_val, wval;
  logic           at_origin, load, in_grid, cell_on;
  logic [4:0]     bsel;
  logic [23:0]    fg_use, bg_use;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    merge = o;
    for (int i = 0; i < 4; i++) if (s[i]) merge[8*i +: 8] = n[8*i +: 8];
  endfunction

  // Write channel: aw and w are captured independently, committed together.
  always_comb begin
    wst_d = wst_q; waddr_d = waddr_q; wdata_d = wdata_q; wstrb_d = wstrb_q; bresp_d = bresp_q;
    fg_d = fg_q; bg_d = bg_q; en_d = en_q;
    for (int i = 0; i < 32; i++) bmp_d[i] = bmp_q[i];
    case (waddr_q)
      A_FG:    old_val = {8'h0, fg_q};
      A_BG:    old_val = {8'h0, bg_q};
      A_CTRL:  old_val = {31'h0, en_q};
      default: old_val = bmp_q[waddr_q[4:0]];
    endcase
    wval = merge(old_val, wdata_q, wstrb_q);
    case (wst_q)
      W_IDLE: begin
        if (s_axi_lite_awvalid) waddr_d = s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
        if (s_axi_lite_wvalid) begin wdata_d = s_axi_lite_wdata; wstrb_d = s_axi_lite_wstrb; end
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) wst_d = W_COMMIT;
        else if (s_axi_lite_awvalid)                 wst_d = W_WAIT_DATA;
        else if (s_axi_lite_wvalid)                  wst_d = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (s_axi_lite_wvalid) begin
        wdata_d = s_axi_lite_wdata; wstrb_d = s_axi_lite_wstrb; wst_d = W_COMMIT;
      end
      W_WAIT_ADDR: if (s_axi_lite_awvalid) begin
        waddr_d = s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2]; wst_d = W_COMMIT;
      end
      W_COMMIT: begin
        bresp_d = 2'b00;
        wst_d   = W_RESP;
        if (waddr_q < A_ROWS) bmp_d[waddr_q[4:0]] = wval;
        else case (waddr_q)
          A_FG:    fg_d = wval[23:0];
          A_BG:    bg_d = wval[23:0];
          A_CTRL:  en_d = wval[0];
          A_STAT:  ;
          default: bresp_d = 2'b10;
        endcase
      end
      W_RESP:  if (s_axi_lite_bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Read channel: one FETCH cycle registers the data, so rvalid lands 2 cycles after ar.
  always_comb begin
    rst_d = rst_q; raddr_d = raddr_q; rdata_d = rdata_q; rresp_d = rresp_q;
    case (rst_q)
      R_IDLE: if (s_axi_lite_arvalid) begin
        raddr_d = s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2]; rst_d = R_FETCH;
      end
      R_FETCH: begin
        rresp_d = 2'b00;
        rst_d   = R_VALID;
        if (raddr_q < A_ROWS) rdata_d = bmp_q[raddr_q[4:0]];
        else case (raddr_q)
          A_FG:    rdata_d = {8'h0, fg_q};
          A_BG:    rdata_d = {8'h0, bg_q};
          A_CTRL:  rdata_d = {31'h0, en_q};
          A_STAT:  rdata_d = {16'h0, fcnt_q, 7'h0, tvalid_q};
          default: begin rdata_d = 32'h0; rresp_d = 2'b10; end
        endcase
      end
      R_VALID: if (s_axi_lite_rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  // Raster: counters name the next pixel to load; the output slice holds the current beat.
  always_comb begin
    x_d = x_q; y_d = y_q; cx_d = cx_q; cy_d = cy_q; col_d = col_q; row_d = row_q;
    tdata_d = tdata_q; tvalid_d = tvalid_q; tuser_d = tuser_q; tlast_d = tlast_q;
    flast_d = flast_q; fg_sh_d = fg_sh_q; bg_sh_d = bg_sh_q; fcnt_d = fcnt_q;
    at_origin = (x_q == 16'h0) && (y_q == 16'h0);
    // A new frame starts only while EN is set; a frame in flight always completes.
    load      = (!at_origin || en_q) && (!tvalid_q || out_stream_tready);
    in_grid   = (col_q < N_COLS) && (row_q < N_ROWS);
    bsel      = ~col_q[4:0];
    cell_on   = in_grid && bmp_q[row_q[4:0]][bsel];
    fg_use    = at_origin ? fg_q : fg_sh_q;
    bg_use    = at_origin ? bg_q : bg_sh_q;
    if (tvalid_q && out_stream_tready) begin
      tvalid_d = 1'b0;
      if (flast_q) fcnt_d = fcnt_q + 8'd1;
    end
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = cell_on ? fg_use : bg_use;
      tuser_d  = at_origin;
      tlast_d  = (x_q == X_LAST);
      flast_d  = (x_q == X_LAST) && (y_q == Y_LAST);
      if (at_origin) begin fg_sh_d = fg_q; bg_sh_d = bg_q; end
      if (x_q == X_LAST) begin
        x_d = 16'h0; cx_d = 16'h0; col_d = 16'h0;
        if (y_q == Y_LAST) begin
          y_d = 16'h0; cy_d = 16'h0; row_d = 16'h0;
        end else begin
          y_d = y_q + 16'd1;
          if (cy_q == CH_LAST) begin cy_d = 16'h0; row_d = row_q + 16'd1; end
          else cy_d = cy_q + 16'd1;
        end
      end else begin
        x_d = x_q + 16'd1;
        if (cx_q == CW_LAST) begin cx_d = 16'h0; col_d = col_q + 16'd1; end
        else cx_d = cx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wst_q <= W_IDLE; rst_q <= R_IDLE;
      waddr_q <= '0; wdata_q <= '0; wstrb_q <= '0; bresp_q <= '0;
      raddr_q <= '0; rdata_q <= '0; rresp_q <= '0;
      for (int i = 0; i < 32; i++) bmp_q[i] <= '0;
      fg_q <= '0; bg_q <= '0; en_q <= 1'b0; fg_sh_q <= '0; bg_sh_q <= '0; fcnt_q <= '0;
      x_q <= '0; y_q <= '0; cx_q <= '0; cy_q <= '0; col_q <= '0; row_q <= '0;
      tdata_q <= '0; tvalid_q <= 1'b0; tuser_q <= 1'b0; tlast_q <= 1'b0; flast_q <= 1'b0;
    end else begin
      wst_q <= wst_d; rst_q <= rst_d;
      waddr_q <= waddr_d; wdata_q <= wdata_d; wstrb_q <= wstrb_d; bresp_q <= bresp_d;
      raddr_q <= raddr_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
      for (int i = 0; i < 32; i++) bmp_q[i] <= bmp_d[i];
      fg_q <= fg_d; bg_q <= bg_d; en_q <= en_d; fg_sh_q <= fg_sh_d; bg_sh_q <= bg_sh_d;
      fcnt_q <= fcnt_d;
      x_q <= x_d; y_q <= y_d; cx_q <= cx_d; cy_q <= cy_d; col_q <= col_d; row_q <= row_d;
      tdata_q <= tdata_d; tvalid_q <= tvalid_d; tuser_q <= tuser_d; tlast_q <= tlast_d;
      flast_q <= flast_d;
    end
  end

  assign s_axi_lite_awready = (wst_q == W_IDLE) || (wst_q == W_WAIT_ADDR);
  assign s_axi_lite_wready  = (wst_q == W_IDLE) || (wst_q == W_WAIT_DATA);
  assign s_axi_lite_bvalid  = (wst_q == W_RESP);
  assign s_axi_lite_bresp   = bresp_q;
  assign s_axi_lite_arready = (rst_q == R_IDLE);
  assign s_axi_lite_rvalid  = (rst_q == R_VALID);
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;
  assign out_stream_tdata   = tdata_q;
  assign out_stream_tvalid  = tvalid_q;
  assign out_stream_tuser   = tuser_q;
  assign out_stream_tlast   = tlast_q;

endmodule

// File: tb/tb_grid_pixel_streamer.sv
// Directed bench for grid_pixel_streamer on a shrunken 16x12 raster of 4x4 cells,
// with a 3x2 grid so the right column and bottom row of cells are out of grid.
module tb_grid_pixel_streamer;

  localparam int XS = 16, YS = 12, FRAME = XS * YS;

  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast;
  logic        tready = 1'b0, tready_fix = 1'b0, rand_mode = 1'b0;

  int errors = 0, checks = 0, stall_viol = 0;

  typedef struct packed { logic [23:0] d; logic u; logic l; } beat_t;
  beat_t q[$];
  logic        prev_stall = 1'b0;
  logic [23:0] prev_d = '0;

  grid_pixel_streamer #(
    .X_SIZE(XS), .Y_SIZE(YS), .CELL_W(4), .CELL_H(4),
    .GRID_COLS(3), .GRID_ROWS(2), .AXI_LITE_ADDR_WIDTH(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .out_stream_tdata(tdata), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .out_stream_tuser(tuser), .out_stream_tlast(tlast)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    tready <= rand_mode ? 1'($urandom_range(0, 1)) : tready_fix;
  end

  // Beats seen at negedge with tvalid&tready are taken at the following posedge.
  always @(negedge aclk) begin
    if (tvalid && tready) q.push_back('{d: tdata, u: tuser, l: tlast});
    if (prev_stall && aresetn && (!tvalid || tdata !== prev_d)) stall_viol <= stall_viol + 1;
    prev_stall <= tvalid && !tready && aresetn;
    prev_d     <= tdata;
  end

  // Cell bitmap used throughout: row0 = cells 0 and 2 lit, row1 = cell 1 lit.
  function automatic logic [23:0] exp_pix(input int i, input logic [23:0] fg, input logic [23:0] bg);
    int x, y, c, r;
    logic [31:0] w;
    x = i % XS; y = (i / XS) % YS; c = x / 4; r = y / 4;
    if (c >= 3 || r >= 2) return bg;
    w = (r == 0) ? 32'hA000_0000 : 32'h4000_0000;
    return w[31-c] ? fg : bg;
  endfunction

  task automatic do_reset();
    aresetn = 1'b0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    rand_mode = 0; tready_fix = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    q.delete();
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output int lat);
    @(negedge aclk); awaddr = a; awvalid = 1; wdata = d; wvalid = 1;
    @(posedge aclk);
    @(negedge aclk); awvalid = 0; wvalid = 0; lat = 1;
    while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
    resp = bresp; bready = 1;
    @(negedge aclk); bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output logic stable);
    @(negedge aclk); araddr = a; arvalid = 1;
    @(posedge aclk);
    @(negedge aclk); arvalid = 0; lat = 1;
    while (!rvalid && lat < 20) begin @(negedge aclk); lat++; end
    d = rdata; resp = rresp;
    @(negedge aclk);
    stable = rvalid && (rdata === d) && (rresp === resp);
    rready = 1;
    @(negedge aclk); rready = 0;
  endtask

  task automatic test_reset();
    @(negedge aclk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++;
      $display("FAIL reset_ready: got %b want 111", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid, tvalid} !== 3'b000) begin errors++;
      $display("FAIL reset_valid: got %b want 000", {bvalid, rvalid, tvalid}); end
    checks++; if ({tdata, tuser, tlast} !== 26'h0) begin errors++;
      $display("FAIL reset_stream: got %h/%b/%b want 0", tdata, tuser, tlast); end
  endtask

  task automatic test_basic();
    logic [1:0] r; int lat, n;
    logic [7:0] adr [4] = '{8'h00, 8'h04, 8'h80, 8'h84};
    logic [31:0] val [4] = '{32'hA000_0000, 32'h4000_0000, 32'h00CB_416B, 32'h0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      axi_write(adr[k], val[k], r, lat);
      checks++; if (r !== 2'b00 || lat !== 2) begin errors++;
        $display("FAIL basic_wr%0d: got resp=%0d lat=%0d want resp=0 lat=2", k, r, lat); end
    end
    @(negedge aclk); awaddr = 8'h88; awvalid = 1; wdata = 32'h1; wvalid = 1; bready = 1;
    @(posedge aclk);
    @(negedge aclk); awvalid = 0; wvalid = 0; n = 1;
    while (!tvalid && n < 10) begin @(negedge aclk); n++; end
    bready = 0;
    checks++; if (n > 4 || tuser !== 1'b1) begin errors++;
      $display("FAIL en_latency: got %0d cycles tuser=%b want <=4 tuser=1", n, tuser); end
    tready_fix = 1;
    n = 0;
    while (q.size() < FRAME && n < 1000) begin @(negedge aclk); n++; end
    checks++; if (q.size() < FRAME) begin errors++;
      $display("FAIL basic_count: got %0d want >=%0d", q.size(), FRAME); end
    for (int i = 0; i < FRAME && i < q.size(); i++) begin
      checks++;
      if (q[i] !== {exp_pix(i, 24'hCB416B, 24'h0), 1'(i == 0), 1'(i % XS == XS - 1)}) begin
        errors++;
        $display("FAIL basic_pix%0d: got %h/%b/%b want %h", i, q[i].d, q[i].u, q[i].l,
                 exp_pix(i, 24'hCB416B, 24'h0));
      end
    end
  endtask

  task automatic test_axi();
    logic [1:0] r; int lat; logic [31:0] d; logic st;
    do_reset();
    @(negedge aclk); awaddr = 8'h00; awvalid = 1;
    @(posedge aclk);
    @(negedge aclk); awvalid = 0;
    checks++; if ({awready, wready} !== 2'b01) begin errors++;
      $display("FAIL split_ready: got %b want 01", {awready, wready}); end
    @(negedge aclk);
    @(negedge aclk); wdata = 32'h8000_0001; wvalid = 1;
    @(posedge aclk);
    @(negedge aclk); wvalid = 0; lat = 1;
    while (!bvalid && lat < 20) begin @(negedge aclk); lat++; end
    checks++; if (bresp !== 2'b00 || lat !== 2) begin errors++;
      $display("FAIL split_wr: got resp=%0d lat=%0d want resp=0 lat=2", bresp, lat); end
    bready = 1; @(negedge aclk); bready = 0;
    axi_read(8'h00, d, r, lat, st);
    checks++; if (d !== 32'h8000_0001 || r !== 2'b00 || lat !== 2 || st !== 1'b1) begin errors++;
      $display("FAIL rd_word0: got %h resp=%0d lat=%0d stable=%b want 80000001 0 2 1", d, r, lat, st); end
    axi_read(8'hA0, d, r, lat, st);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL rd_word40: got %h resp=%0d want 0 resp=2", d, r); end
    axi_read(8'h08, d, r, lat, st);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL rd_row_oob: got %h resp=%0d want 0 resp=2", d, r); end
    axi_write(8'hA0, 32'h1234, r, lat);
    checks++; if (r !== 2'b10) begin errors++;
      $display("FAIL wr_word40: got resp=%0d want 2", r); end
    axi_write(8'h8C, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 2'b00) begin errors++;
      $display("FAIL wr_status: got resp=%0d want 0", r); end
    axi_read(8'h8C, d, r, lat, st);
    checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++;
      $display("FAIL rd_status: got %h resp=%0d want 0 0", d, r); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; int lat, n; logic [31:0] d; logic st; logic [23:0] fg;
    do_reset();
    rand_mode = 1;
    axi_write(8'h00, 32'hA000_0000, r, lat);
    axi_write(8'h04, 32'h4000_0000, r, lat);
    axi_write(8'h80, 32'h00CB_416B, r, lat);
    axi_write(8'h84, 32'h0011_2233, r, lat);
    axi_write(8'h88, 32'h1, r, lat);
    n = 0; while (q.size() < 100 && n < 3000) begin @(negedge aclk); n++; end
    axi_write(8'h80, 32'h0000_FF00, r, lat);
    n = 0; while (q.size() < 250 && n < 3000) begin @(negedge aclk); n++; end
    axi_write(8'h88, 32'h0, r, lat);
    n = 0; while ((q.size() < 2 * FRAME || tvalid) && n < 3000) begin @(negedge aclk); n++; end
    repeat (20) @(negedge aclk);
    checks++; if (q.size() !== 2 * FRAME) begin errors++;
      $display("FAIL bp_count: got %0d want %0d", q.size(), 2 * FRAME); end
    checks++; if (stall_viol !== 0) begin errors++;
      $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_viol); end
    checks++; if (tvalid !== 1'b0) begin errors++;
      $display("FAIL bp_park: got tvalid=%b want 0", tvalid); end
    for (int i = 0; i < 2 * FRAME && i < q.size(); i++) begin
      fg = (i < FRAME) ? 24'hCB416B : 24'h00FF00;
      checks++;
      if (q[i] !== {exp_pix(i, fg, 24'h112233), 1'(i % FRAME == 0), 1'(i % XS == XS - 1)}) begin
        errors++;
        $display("FAIL bp_pix%0d: got %h/%b/%b want %h", i, q[i].d, q[i].u, q[i].l,
                 exp_pix(i, fg, 24'h112233));
      end
    end
    axi_read(8'h8C, d, r, lat, st);
    checks++; if (d !== 32'h0000_0200) begin errors++;
      $display("FAIL bp_status: got %h want 00000200", d); end
  endtask

  task automatic test_reset_midrun();
    logic [1:0] r; int lat, n; logic [31:0] d; logic st; logic seen_b;
    logic [7:0] adr [6] = '{8'h00, 8'h04, 8'h80, 8'h84, 8'h88, 8'h8C};
    rand_mode = 0; tready_fix = 1;
    axi_write(8'h88, 32'h1, r, lat);
    q.delete();
    n = 0; while (q.size() < 50 && n < 1000) begin @(negedge aclk); n++; end
    @(negedge aclk); awaddr = 8'h84; awvalid = 1;
    @(posedge aclk); #2;
    checks++; if (tvalid !== 1'b1) begin errors++;
      $display("FAIL mid_running: got tvalid=%b want 1", tvalid); end
    aresetn = 1'b0; #1;
    checks++; if ({tvalid, tuser, tlast, tdata} !== 27'h0) begin errors++;
      $display("FAIL async_rst: got tvalid=%b tdata=%h want 0", tvalid, tdata); end
    checks++; if ({awready, wready, arready, bvalid} !== 4'b1110) begin errors++;
      $display("FAIL async_rst_axi: got %b want 1110", {awready, wready, arready, bvalid}); end
    awvalid = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1; seen_b = 0;
    repeat (5) begin @(negedge aclk); seen_b |= bvalid | tvalid; end
    checks++; if (seen_b !== 1'b0) begin errors++;
      $display("FAIL drop_partial: got bvalid/tvalid=%b want 0", seen_b); end
    for (int k = 0; k < 6; k++) begin
      axi_read(adr[k], d, r, lat, st);
      checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++;
        $display("FAIL rst_reg%0h: got %h resp=%0d want 0", adr[k], d, r); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_axi();
    test_backpressure();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
